// File: rtl/uart_echo_checker.sv
// Self-checking UART link partner: sends an incrementing byte pattern over 8N1,
// waits for each echo, and tallies passes, mismatches/framing errors and timeouts.
module uart_echo_checker #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           num_bytes,
    output logic                  tx_wire,
    input  logic                  rx_wire,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pass_cnt,
    output logic [15:0]           err_cnt,
    output logic [15:0]           timeout_cnt,
    output logic [DATA_WIDTH-1:0] last_exp,
    output logic [DATA_WIDTH-1:0] last_got
);
    localparam int BAUD_DIV    = CLK_FREQ / BAUD_RATE;
    localparam int HALF_DIV    = BAUD_DIV / 2;
    localparam int FRAME_BITS  = DATA_WIDTH + 2;
    localparam int TIMEOUT_CYC = TIMEOUT_FRAMES * FRAME_BITS * BAUD_DIV;
    localparam int BW          = $clog2(BAUD_DIV);
    localparam int IW          = $clog2(FRAME_BITS);
    localparam int TW          = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, DONE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    rx_state_t             rx_state;
    logic                  rx_s1, rx_s2, rx_prev;
    logic [BW-1:0]         rx_baud;
    logic [IW-1:0]         rx_idx;
    logic [DATA_WIDTH-1:0] rx_shift, rx_data;
    logic                  rx_valid, rx_ferr;

    // Deserializer: always listening; samples the synchronized line at bit centres.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_baud  <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= rx_wire;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= R_START;
                        rx_baud  <= '0;
                    end
                end
                R_START: begin
                    if (rx_baud == BW'(HALF_DIV - 1)) begin
                        rx_baud  <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_baud == BW'(BAUD_DIV - 1)) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
                        if (rx_idx == IW'(DATA_WIDTH - 1)) rx_state <= R_STOP;
                        else                               rx_idx   <= rx_idx + 1'b1;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_baud == BW'(BAUD_DIV - 1)) begin
                        rx_valid <= 1'b1;
                        rx_ferr  <= !rx_s2;
                        rx_data  <= rx_shift;
                        rx_state <= R_IDLE;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    state_t                state;
    logic [DATA_WIDTH-1:0] pattern;
    logic [15:0]           remaining;
    logic [DATA_WIDTH:0]   tx_shift;
    logic [BW-1:0]         tx_baud;
    logic [IW-1:0]         tx_idx;
    logic [TW-1:0]         to_cnt;
    logic                  hold_vld, hold_ferr, got_ferr;
    logic [DATA_WIDTH-1:0] hold_data, got_data;

    logic                  byte_in, timed_out, advance;
    logic [DATA_WIDTH-1:0] next_pattern;

    // A byte arriving on the timeout cycle wins over the timeout.
    assign byte_in      = rx_valid || hold_vld;
    assign timed_out    = (state == WAIT) && !byte_in && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign advance      = (state == CHECK) || timed_out;
    assign next_pattern = pattern + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_wire     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= '0;
            err_cnt     <= '0;
            timeout_cnt <= '0;
            last_exp    <= '0;
            last_got    <= '0;
            pattern     <= '0;
            remaining   <= '0;
            tx_shift    <= '1;
            tx_baud     <= '0;
            tx_idx      <= '0;
            to_cnt      <= '0;
            hold_vld    <= 1'b0;
            hold_ferr   <= 1'b0;
            hold_data   <= '0;
            got_ferr    <= 1'b0;
            got_data    <= '0;
        end else begin
            if (state != SEND) hold_vld <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pass_cnt    <= '0;
                        err_cnt     <= '0;
                        timeout_cnt <= '0;
                        last_exp    <= '0;
                        last_got    <= '0;
                        pattern     <= '0;
                        remaining   <= num_bytes;
                        if (num_bytes == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= SEND;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            tx_wire  <= 1'b0;
                            tx_shift <= {1'b1, {DATA_WIDTH{1'b0}}};
                            tx_baud  <= '0;
                            tx_idx   <= '0;
                        end
                    end
                end
                SEND: begin
                    // An echo finishing before our own stop bit ends is kept for WAIT.
                    if (rx_valid) begin
                        hold_vld  <= 1'b1;
                        hold_data <= rx_data;
                        hold_ferr <= rx_ferr;
                    end
                    if (tx_baud == BW'(BAUD_DIV - 1)) begin
                        tx_baud <= '0;
                        if (tx_idx == IW'(FRAME_BITS - 1)) begin
                            state  <= WAIT;
                            to_cnt <= '0;
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_wire  <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[DATA_WIDTH:1]};
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                WAIT: begin
                    if (rx_valid) begin
                        got_data <= rx_data;
                        got_ferr <= rx_ferr;
                        state    <= CHECK;
                    end else if (hold_vld) begin
                        got_data <= hold_data;
                        got_ferr <= hold_ferr;
                        state    <= CHECK;
                    end else if (timed_out) begin
                        timeout_cnt <= sat_inc(timeout_cnt);
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (got_data == pattern && !got_ferr) begin
                        pass_cnt <= sat_inc(pass_cnt);
                    end else begin
                        err_cnt  <= sat_inc(err_cnt);
                        last_exp <= pattern;
                        last_got <= got_data;
                    end
                end
                default: state <= IDLE;
            endcase

            if (advance) begin
                pattern   <= next_pattern;
                remaining <= remaining - 16'd1;
                if (remaining == 16'd1) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state    <= SEND;
                    tx_wire  <= 1'b0;
                    tx_shift <= {1'b1, next_pattern};
                    tx_baud  <= '0;
                    tx_idx   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: direct, echo-model and silent-line runs checked
// against a per-byte outcome model plus a bit-level monitor of the transmit line.
module tb_uart_echo_checker;
    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int BD         = 10;
    localparam int FRAME_BITS = 10;
    localparam int K_OK = 0, K_FLIP = 1, K_FERR = 2, K_DROP = 3, K_GLITCH = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, tx_wire, rx_wire, busy, done;
    logic [15:0] num_bytes, pass_cnt, err_cnt, timeout_cnt;
    logic [7:0]  last_exp, last_got;

    uart_echo_checker #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(8), .TIMEOUT_FRAMES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_bytes(num_bytes),
        .tx_wire(tx_wire), .rx_wire(rx_wire), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .timeout_cnt(timeout_cnt),
        .last_exp(last_exp), .last_got(last_got)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    endtask

    // Line routing: 0 = direct wire, 1 = echo model, 2 = line held idle.
    int   mode = 0;
    logic echo_line = 1'b1;
    assign rx_wire = (mode == 0) ? tx_wire : ((mode == 1) ? echo_line : 1'b1);

    int       kind [0:511];
    logic [7:0] mask [0:511];
    int       dly  [0:511];
    logic [7:0] echo_q [$];
    int       echo_idx = 0;
    int       mon_idx  = 0;
    bit       mon_en   = 1'b1;

    int       exp_pass, exp_err, exp_to;
    logic [7:0] exp_last_exp, exp_last_got;

    task automatic clear_plan();
        for (int i = 0; i < 512; i++) begin
            kind[i] = K_OK;
            mask[i] = 8'h00;
            dly[i]  = 0;
        end
    endtask

    // Outcome model: byte i carries pattern i mod 256; its fate follows the plan.
    task automatic prep(input int m, input int n);
        logic [7:0] p;
        mode = m;
        exp_pass = 0; exp_err = 0; exp_to = 0;
        exp_last_exp = 8'h00; exp_last_got = 8'h00;
        for (int i = 0; i < n; i++) begin
            p = 8'(i % 256);
            if (m == 0) exp_pass++;
            else if (m == 2) exp_to++;
            else if (kind[i] == K_OK || kind[i] == K_GLITCH) exp_pass++;
            else if (kind[i] == K_DROP) exp_to++;
            else begin
                exp_err++;
                exp_last_exp = p;
                exp_last_got = (kind[i] == K_FLIP) ? (p ^ mask[i]) : p;
            end
        end
        if (exp_pass > 65535) exp_pass = 65535;
        echo_q.delete();
        echo_idx = 0;
        mon_idx  = 0;
    endtask

    task automatic go(input int n);
        int t;
        @(negedge clk);
        start = 1'b1;
        num_bytes = 16'(n);
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!done && t < n * 700 + 300) begin
            @(negedge clk);
            t++;
        end
        check("run reaches done", done, 1);
    endtask

    // Echo model, receive half: decode each frame the DUT sends.
    initial begin : echo_rx
        logic prev;
        logic [7:0] d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mode == 1 && rst_n && prev && !tx_wire) begin
                repeat (BD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    d[i] = tx_wire;
                end
                repeat (BD) @(negedge clk);
                echo_q.push_back(d);
            end
            prev = tx_wire;
        end
    end

    // Echo model, transmit half: returns each byte as the plan dictates.
    initial begin : echo_tx
        logic [7:0] d;
        int k;
        forever begin
            @(negedge clk);
            if (echo_q.size() > 0) begin
                d = echo_q.pop_front();
                k = echo_idx;
                echo_idx++;
                if (kind[k] != K_DROP) begin
                    repeat (dly[k]) @(negedge clk);
                    if (kind[k] == K_GLITCH) begin
                        echo_line = 1'b0;
                        repeat (3) @(negedge clk);
                        echo_line = 1'b1;
                        repeat (20) @(negedge clk);
                    end
                    if (kind[k] == K_FLIP) d = d ^ mask[k];
                    echo_line = 1'b0;
                    repeat (BD) @(negedge clk);
                    for (int i = 0; i < 8; i++) begin
                        echo_line = d[i];
                        repeat (BD) @(negedge clk);
                    end
                    echo_line = (kind[k] == K_FERR) ? 1'b0 : 1'b1;
                    repeat (BD) @(negedge clk);
                    echo_line = 1'b1;
                end
            end
        end
    end

    // Transmit monitor: every bit of frame j must hold its value for exactly BD cycles.
    initial begin : tx_mon
        logic prev;
        logic [9:0] fr;
        logic [7:0] bv;
        int ok;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && prev && !tx_wire) begin
                bv = mon_idx[7:0];
                fr = {1'b1, bv, 1'b0};
                mon_idx++;
                for (int b = 0; b < FRAME_BITS; b++) begin
                    ok = 0;
                    for (int c = 0; c < BD; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (tx_wire == fr[b]) ok++;
                    end
                    if (mon_en) check("tx bit cycles at level", ok, BD);
                end
            end
            prev = tx_wire;
        end
    end

    // Compare process: whenever a run completes, all results must match the model.
    initial begin : compare
        logic dq;
        dq = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && done && !dq) begin
                check("pass_cnt", pass_cnt, exp_pass);
                check("err_cnt", err_cnt, exp_err);
                check("timeout_cnt", timeout_cnt, exp_to);
                check("last_exp", last_exp, exp_last_exp);
                check("last_got", last_got, exp_last_got);
                check("busy low in done", busy, 0);
            end
            dq = done;
        end
    end

    initial begin : main
        int t, c0;
        logic [15:0] prev_to;
        int n, r;

        rst_n = 1'b0; start = 1'b0; num_bytes = 16'd0;
        clear_plan();
        repeat (3) @(negedge clk);
        check("reset tx_wire", tx_wire, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset pass_cnt", pass_cnt, 0);
        check("reset err_cnt", err_cnt, 0);
        check("reset timeout_cnt", timeout_cnt, 0);
        rst_n = 1'b1;

        // Direct wire, pattern wraps past 0xFF.
        prep(0, 300);
        @(negedge clk);
        start = 1'b1; num_bytes = 16'd300;
        @(negedge clk);
        start = 1'b0;
        check("busy with first start bit", busy, 1);
        check("tx low after start", tx_wire, 0);
        t = 0;
        while (!done && t < 40000) begin @(negedge clk); t++; end
        check("direct run done", done, 1);
        check("direct pass literal", pass_cnt, 300);

        // Bit 3 of the 6th byte flipped.
        clear_plan();
        kind[5] = K_FLIP; mask[5] = 8'h08;
        prep(1, 10);
        go(10);
        check("flip pass literal", pass_cnt, 9);
        check("flip err literal", err_cnt, 1);
        check("flip last_exp literal", last_exp, 8'h05);
        check("flip last_got literal", last_got, 8'h0D);

        // Silent line: each timeout lands 100 + 400 cycles after its start bit.
        clear_plan();
        prep(2, 3);
        @(negedge clk);
        start = 1'b1; num_bytes = 16'd3;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            t = 0;
            while (tx_wire && t < 1000) begin @(negedge clk); t++; end
            c0 = cyc;
            prev_to = timeout_cnt;
            t = 0;
            while (timeout_cnt == prev_to && t < 1000) begin @(negedge clk); t++; end
            check("timeout delay from start bit", cyc - c0, 500);
        end
        @(negedge clk);
        check("timeout done", done, 1);
        check("timeout literal", timeout_cnt, 3);

        // Framing error on byte 2, false-start glitch before echo of byte 1.
        clear_plan();
        kind[1] = K_GLITCH; dly[1] = 30;
        kind[2] = K_FERR;
        prep(1, 4);
        go(4);
        check("ferr err literal", err_cnt, 1);
        check("ferr pass literal", pass_cnt, 3);

        // Randomized plans.
        for (int run = 0; run < 3; run++) begin
            clear_plan();
            n = $urandom_range(6, 16);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                kind[i] = (r <= 5) ? K_OK : (r == 6) ? K_FLIP : (r == 7) ? K_FERR :
                          (r == 8) ? K_DROP : K_GLITCH;
                mask[i] = 8'($urandom_range(1, 255));
                dly[i]  = $urandom_range(0, 150);
            end
            prep(1, n);
            go(n);
        end

        // Reset during the 4th frame, then an empty run.
        clear_plan();
        prep(0, 10);
        @(negedge clk);
        start = 1'b1; num_bytes = 16'd10;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (mon_idx < 4 && t < 2000) begin @(negedge clk); t++; end
        check("fourth frame started", mon_idx, 4);
        mon_en = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-run reset tx_wire", tx_wire, 1);
        check("mid-run reset busy", busy, 0);
        check("mid-run reset pass_cnt", pass_cnt, 0);
        check("mid-run reset done", done, 0);
        rst_n = 1'b1;
        prep(0, 0);
        @(negedge clk);
        start = 1'b1; num_bytes = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("empty run done next cycle", done, 1);
        check("empty run busy", busy, 0);
        t = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_wire == 1'b1) t++;
        end
        check("empty run tx idle cycles", t, 5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
